// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite responder with a bank of NUM_REGS 32-bit read/write registers.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   AWADDR/AWVALID/AWREADY         write-address channel
//   WDATA/WSTRB/WVALID/WREADY      write-data channel (byte strobes)
//   BRESP/BVALID/BREADY            write-response channel (OKAY / SLVERR)
//   ARADDR/ARVALID/ARREADY         read-address channel
//   RDATA/RRESP/RVALID/RREADY      read-data channel
//   regOut                         all registers in parallel, reg k at [32k+31:32k]
//
// Word index is addr[ADDR_W-1:2]; addr[1:0] is ignored. Indices >= NUM_REGS
// answer SLVERR and leave the bank untouched. One write outstanding at a time.
module axi_lite_reg_slave #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        AWADDR,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [31:0]              WDATA,
    input  logic [3:0]               WSTRB,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    input  logic [ADDR_W-1:0]        ARADDR,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [31:0]              RDATA,
    output logic [1:0]               RRESP,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [NUM_REGS*32-1:0]   regOut
);

    localparam int unsigned IdxW = ADDR_W - 2;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    // State
    logic                         aw_got_q, aw_got_d;
    logic [IdxW-1:0]              aw_idx_q, aw_idx_d;
    logic                         w_got_q, w_got_d;
    logic [31:0]                  w_data_q, w_data_d;
    logic [3:0]                   w_strb_q, w_strb_d;
    logic                         bvalid_q, bvalid_d;
    logic [1:0]                   bresp_q, bresp_d;
    logic                         rvalid_q, rvalid_d;
    logic [31:0]                  rdata_q, rdata_d;
    logic [1:0]                   rresp_q, rresp_d;
    logic [NUM_REGS-1:0][31:0]    regs_q, regs_d;

    // Combinational helpers
    logic            aw_hs, w_hs, ar_hs, commit;
    logic [IdxW-1:0] wr_idx, rd_idx;
    logic [31:0]     wr_data;
    logic [3:0]      wr_strb;
    logic            wr_in_range, rd_in_range;
    logic [31:0]     rd_word;

    // Byte-offset bits carry no meaning for word registers.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

    // READYs are low throughout reset and never look at VALID.
    assign AWREADY = rst & ~aw_got_q & ~bvalid_q;
    assign WREADY  = rst & ~w_got_q & ~bvalid_q;
    assign ARREADY = rst & ~rvalid_q;

    assign aw_hs = AWVALID & AWREADY;
    assign w_hs  = WVALID & WREADY;
    assign ar_hs = ARVALID & ARREADY;

    // Commit when both halves are present, counting a handshake on this edge.
    assign commit = (aw_got_q | aw_hs) & (w_got_q | w_hs);

    assign wr_idx  = aw_got_q ? aw_idx_q : AWADDR[ADDR_W-1:2];
    assign wr_data = w_got_q ? w_data_q : WDATA;
    assign wr_strb = w_got_q ? w_strb_q : WSTRB;
    assign rd_idx  = ARADDR[ADDR_W-1:2];

    assign wr_in_range = 32'(wr_idx) < NUM_REGS;
    assign rd_in_range = 32'(rd_idx) < NUM_REGS;

    // Read mux works from pre-commit contents, so a same-edge write is not seen.
    always_comb begin
        rd_word = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (32'(rd_idx) == k) begin
                rd_word = regs_q[k];
            end
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (commit && wr_in_range) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (32'(wr_idx) == k) begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (wr_strb[b]) begin
                            regs_d[k][8*b +: 8] = wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Write channel bookkeeping
    always_comb begin
        aw_got_d = aw_got_q;
        aw_idx_d = aw_idx_q;
        w_got_d  = w_got_q;
        w_data_d = w_data_q;
        w_strb_d = w_strb_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;

        if (aw_hs) begin
            aw_got_d = 1'b1;
            aw_idx_d = AWADDR[ADDR_W-1:2];
        end
        if (w_hs) begin
            w_got_d  = 1'b1;
            w_data_d = WDATA;
            w_strb_d = WSTRB;
        end

        if (commit) begin
            aw_got_d = 1'b0;
            w_got_d  = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = wr_in_range ? RespOkay : RespSlverr;
        end else if (bvalid_q && BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    // Read channel
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
            rresp_d  = rd_in_range ? RespOkay : RespSlverr;
        end else if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_got_q <= 1'b0;
            aw_idx_q <= '0;
            w_got_q  <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RespOkay;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RespOkay;
            regs_q   <= '0;
        end else begin
            aw_got_q <= aw_got_d;
            aw_idx_q <= aw_idx_d;
            w_got_q  <= w_got_d;
            w_data_q <= w_data_d;
            w_strb_q <= w_strb_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            regs_q   <= regs_d;
        end
    end

    assign BVALID = bvalid_q;
    assign BRESP  = bresp_q;
    assign RVALID = rvalid_q;
    assign RDATA  = rdata_q;
    assign RRESP  = rresp_q;
    assign regOut = regs_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: fixed vector table, directed
// corner sequences and randomized traffic against an array-based register model.
module tb_axi_lite_reg_slave;

    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [ADDR_W-1:0]      AWADDR = '0;
    logic                   AWVALID = 1'b0;
    logic                   AWREADY;
    logic [31:0]            WDATA = '0;
    logic [3:0]             WSTRB = '0;
    logic                   WVALID = 1'b0;
    logic                   WREADY;
    logic [1:0]             BRESP;
    logic                   BVALID;
    logic                   BREADY = 1'b0;
    logic [ADDR_W-1:0]      ARADDR = '0;
    logic                   ARVALID = 1'b0;
    logic                   ARREADY;
    logic [31:0]            RDATA;
    logic [1:0]             RRESP;
    logic                   RVALID;
    logic                   RREADY = 1'b0;
    logic [NUM_REGS*32-1:0] regOut;

    axi_lite_reg_slave #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst(rst),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .regOut(regOut)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain array of words.
    logic [31:0] model [NUM_REGS];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < NUM_REGS; k++) model[k] = 32'h0;
    endfunction

    function automatic logic [1:0] model_write(input logic [4:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        int idx;
        idx = int'(a) / 4;
        if (idx >= NUM_REGS) return 2'b10;
        for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
        return 2'b00;
    endfunction

    function automatic void model_read(input logic [4:0] a, output logic [31:0] d,
                                       output logic [1:0] r);
        int idx;
        idx = int'(a) / 4;
        if (idx >= NUM_REGS) begin
            d = 32'h0;
            r = 2'b10;
        end else begin
            d = model[idx];
            r = 2'b00;
        end
    endfunction

    function automatic logic [127:0] model_regout();
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < NUM_REGS; k++) v[32*k +: 32] = model[k];
        return v;
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp);
        bit aw_done, w_done, aw_v, w_v;
        int c;
        logic [1:0] exp_resp;
        aw_done = 0; w_done = 0; c = 0;
        AWADDR = a; WDATA = d; WSTRB = s; BREADY = 1'b0;
        while (!(aw_done && w_done) && c < 40) begin
            aw_v = !aw_done && c >= aw_dly;
            w_v  = !w_done && c >= w_dly;
            AWVALID = aw_v;
            WVALID  = w_v;
            @(negedge clk);
            check("bvalid_early", BVALID, 1'b0);
            if (aw_v && AWREADY) aw_done = 1;
            if (w_v && WREADY) w_done = 1;
            @(posedge clk); #1;
            c++;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        check("wr_handshake_done", {aw_done, w_done}, 2'b11);
        exp_resp = model_write(a, d, s);
        @(negedge clk);
        check("bvalid_after_commit", BVALID, 1'b1);
        check("bresp", BRESP, exp_resp);
        check("regout_after_commit", regOut, model_regout());
        for (int i = 0; i < b_dly; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("bvalid_held", BVALID, 1'b1);
            check("bresp_held", BRESP, exp_resp);
            check("aw_w_ready_blocked", {AWREADY, WREADY}, 2'b00);
        end
        @(posedge clk); #1;
        BREADY = 1'b1;
        @(negedge clk);
        resp = BRESP;
        @(posedge clk); #1;
        BREADY = 1'b0;
        @(negedge clk);
        check("bvalid_cleared", BVALID, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [4:0] a, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp);
        bit done;
        int c;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        done = 0; c = 0;
        ARADDR = a; RREADY = 1'b0;
        model_read(a, exp_d, exp_r);
        while (!done && c < 20) begin
            ARVALID = 1'b1;
            @(negedge clk);
            if (ARREADY) done = 1;
            @(posedge clk); #1;
            c++;
        end
        ARVALID = 1'b0;
        check("rd_handshake_done", done, 1'b1);
        @(negedge clk);
        check("rvalid_after_ar", RVALID, 1'b1);
        check("rdata", RDATA, exp_d);
        check("rresp", RRESP, exp_r);
        for (int i = 0; i < r_dly; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rvalid_held", RVALID, 1'b1);
            check("rdata_held", {RDATA, RRESP}, {exp_d, exp_r});
            check("arready_blocked", ARREADY, 1'b0);
        end
        @(posedge clk); #1;
        RREADY = 1'b1;
        @(negedge clk);
        data = RDATA;
        resp = RRESP;
        @(posedge clk); #1;
        RREADY = 1'b0;
        @(negedge clk);
        check("rvalid_cleared", RVALID, 1'b0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;

        vecs[0] = '{1, 5'h00, 32'h12345678, 4'hF, 32'h0,        2'b00};
        vecs[1] = '{0, 5'h00, 32'h0,        4'h0, 32'h12345678, 2'b00};
        vecs[2] = '{1, 5'h10, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10};
        vecs[3] = '{0, 5'h1C, 32'h0,        4'h0, 32'h0,        2'b10};
        vecs[4] = '{1, 5'h0C, 32'h99999999, 4'h0, 32'h0,        2'b00};
        vecs[5] = '{0, 5'h0C, 32'h0,        4'h0, 32'h0,        2'b00};
        vecs[6] = '{1, 5'h0E, 32'hAABBCCDD, 4'h3, 32'h0,        2'b00};
        vecs[7] = '{0, 5'h0F, 32'h0,        4'h0, 32'h0000CCDD, 2'b00};
        vecs[8] = '{1, 5'h00, 32'hFFFFFFFF, 4'h8, 32'h0,        2'b00};
        vecs[9] = '{0, 5'h03, 32'h0,        4'h0, 32'hFF345678, 2'b00};

        model_clear();

        // Reset: readies forced low, then high on the first cycle after release.
        @(negedge clk);
        check("ready_in_reset", {AWREADY, WREADY, ARREADY}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {AWREADY, WREADY, ARREADY}, 3'b111);
        @(posedge clk); #1;

        // Reset mid-write: AW accepted, W pending, bank non-zero.
        do_write(5'h00, 32'hCAFEF00D, 4'hF, 0, 0, 0, r);
        AWADDR = 5'h04; AWVALID = 1'b1;
        @(posedge clk); #1;
        AWVALID = 1'b0;
        @(negedge clk);
        check("aw_held_pending", {AWREADY, WREADY}, 2'b01);
        #1 rst = 1'b0;
        #1;
        check("ready_forced_low", {AWREADY, WREADY, ARREADY}, 3'b000);
        check("regout_reset", regOut, 128'h0);
        check("bvalid_reset", {BVALID, RVALID}, 2'b00);
        model_clear();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rerelease", {AWREADY, WREADY, ARREADY}, 3'b111);
        check("regout_after_release", regOut, 128'h0);
        check("valids_after_release", {BVALID, RVALID}, 2'b00);
        @(posedge clk); #1;
        // W before AW: a stale address flag would commit early.
        do_write(5'h00, 32'h01020304, 4'hF, 2, 0, 0, r);

        // Fixed vector table.
        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, r);
                check($sformatf("vec%0d_bresp", i), r, vecs[i].exp_resp);
            end else begin
                do_read(vecs[i].addr, 0, d, r);
                check($sformatf("vec%0d_rdata", i), {d, r}, {vecs[i].exp_data, vecs[i].exp_resp});
            end
        end

        // Full strobe write, then readback.
        do_write(5'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, r);
        check("full_wr_bresp", r, 2'b00);
        check("full_wr_regout", regOut[63:32], 32'hDEADBEEF);
        do_read(5'h04, 0, d, r);
        check("full_wr_read", {d, r}, {32'hDEADBEEF, 2'b00});

        // Partial strobes, W three cycles ahead of AW.
        do_write(5'h04, 32'h11223344, 4'b0101, 3, 0, 0, r);
        check("partial_regout", regOut[63:32], 32'hDE22BE44);
        do_read(5'h04, 0, d, r);
        check("partial_read", d, 32'hDE22BE44);

        // Out of range write and read.
        do_write(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0, r);
        check("oor_bresp", r, 2'b10);
        do_read(5'h1C, 0, d, r);
        check("oor_read", {d, r}, {32'h0, 2'b10});

        // Back-pressure on both response channels.
        do_write(5'h08, 32'h00000077, 4'hF, 0, 0, 5, r);
        do_read(5'h04, 5, d, r);
        check("bp_read", d, 32'hDE22BE44);

        // Read and write commit to reg2 on the same edge.
        do_write(5'h08, 32'h0000000A, 4'hF, 0, 0, 0, r);
        AWADDR = 5'h08; WDATA = 32'h0000000B; WSTRB = 4'hF; ARADDR = 5'h08;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        @(negedge clk);
        check("sim_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        void'(model_write(5'h08, 32'h0000000B, 4'hF));
        @(negedge clk);
        check("sim_rdata_old", {RVALID, RDATA, RRESP}, {1'b1, 32'h0000000A, 2'b00});
        check("sim_bvalid", {BVALID, BRESP}, {1'b1, 2'b00});
        check("sim_regout", regOut[95:64], 32'h0000000B);
        @(posedge clk); #1;
        BREADY = 1'b1; RREADY = 1'b1;
        @(posedge clk); #1;
        BREADY = 1'b0; RREADY = 1'b0;
        @(negedge clk);
        check("sim_cleared", {BVALID, RVALID}, 2'b00);
        @(posedge clk); #1;
        do_read(5'h08, 0, d, r);
        check("sim_followup", d, 32'h0000000B);

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            logic [4:0]  a;
            logic [31:0] wd;
            logic [3:0]  ws;
            a  = 5'($urandom_range(0, 31));
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                exp_r = (int'(a) / 4 < NUM_REGS) ? 2'b00 : 2'b10;
                do_write(a, wd, ws, $urandom_range(0, 2), $urandom_range(0, 2),
                         $urandom_range(0, 2), r);
                check("rand_bresp", r, exp_r);
            end else begin
                model_read(a, exp_d, exp_r);
                do_read(a, $urandom_range(0, 2), d, r);
                check("rand_read", {d, r}, {exp_d, exp_r});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
